// File: rtl/burst_slave.sv
// Burst slave: 256x8 store behind independent read and write burst FSMs (optional macro BURST_SLAVE_WRAP_ERR_EN flags address wrap as error).
// Latency: address accept pulse 1 cycle after ARVALID/AWVALID sampled, first read beat on the following cycle; one beat per cycle.
// Backpressure: read beat held stable until RREADY, write response held until BREADY; WREADY high for the whole data phase.
module burst_slave (
   input  logic        clk,
   input  logic        rst,
   input  logic        ARVALID,
   input  logic [15:0] AR,
   output logic        ARREADY,
   output logic        RVALID,
   output logic        RLAST,
   output logic [8:0]  RDOUT,
   input  logic        RREADY,
   output logic        RIDLE,
   input  logic        AWVALID,
   input  logic [11:0] AW,
   output logic        AWREADY,
   input  logic        WVALID,
   input  logic        WLAST,
   input  logic [7:0]  WDATA,
   output logic        WREADY,
   output logic        BVALID,
   output logic [4:0]  BRESP,
   input  logic        BREADY,
   output logic        WIDLE
);

`ifdef BURST_SLAVE_WRAP_ERR_EN
   localparam logic C_WRAP_ERR = 1'b1;
`else
   localparam logic C_WRAP_ERR = 1'b0;
`endif

   typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_ACK, W_DATA, W_RESP} wstate_t;

   logic [7:0] r_mem [0:255];

   rstate_t    r_rstate, w_rnext;
   logic [7:0] r_raddr;
   logic [3:0] r_rlen;
   logic [3:0] r_rbeat;
   logic       r_rwrap;
   logic [8:0] r_rdout;

   wstate_t    r_wstate, w_wnext;
   logic [7:0] r_waddr;
   logic [3:0] r_wid;
   logic [4:0] r_wcnt;
   logic       r_werr;
   logic       r_wwrap;

   // ARID is not returned on the read channel
   logic       w_unused_arid;
   assign w_unused_arid = ^AR[3:0];

   logic       w_rhs, w_rlast, w_rwrap_nxt, w_whs, w_wfull;
   logic [7:0] w_raddr_nxt;

   assign w_rlast     = (r_rstate == R_DATA) && (r_rbeat == r_rlen);
   assign w_rhs       = (r_rstate == R_DATA) && RREADY;
   assign w_raddr_nxt = r_raddr + 8'd1;
   assign w_rwrap_nxt = r_rwrap | (r_raddr == 8'hFF);
   assign w_whs       = (r_wstate == W_DATA) && WVALID;
   assign w_wfull     = r_wcnt[4];

   assign RLAST = w_rlast;
   assign RDOUT = RVALID ? r_rdout : 9'd0;
   assign BRESP = BVALID ? {r_wid, r_werr} : 5'd0;

   // Read FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_rstate <= R_IDLE;
      else      r_rstate <= w_rnext;
   end

   // Read FSM next state and handshake outputs
   always_comb begin
      w_rnext = r_rstate;
      ARREADY = 1'b0;
      RVALID  = 1'b0;
      RIDLE   = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            RIDLE = 1'b1;
            if (ARVALID) w_rnext = R_ACK;
         end
         R_ACK: begin
            ARREADY = 1'b1;
            w_rnext = R_DATA;
         end
         R_DATA: begin
            RVALID = 1'b1;
            if (RREADY && (r_rbeat == r_rlen)) w_rnext = R_IDLE;
         end
         default: w_rnext = R_IDLE;
      endcase
   end

   // Read burst tracking; beat data is registered so it stays put during a stall
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_raddr <= 8'd0;
         r_rlen  <= 4'd0;
         r_rbeat <= 4'd0;
         r_rwrap <= 1'b0;
         r_rdout <= 9'd0;
      end else begin
         if (r_rstate == R_IDLE && ARVALID) begin
            r_raddr <= AR[15:8];
            r_rlen  <= AR[7:4];
            r_rbeat <= 4'd0;
            r_rwrap <= 1'b0;
         end
         if (r_rstate == R_ACK) r_rdout <= {r_mem[r_raddr], 1'b0};
         if (w_rhs && !w_rlast) begin
            r_raddr <= w_raddr_nxt;
            r_rbeat <= r_rbeat + 4'd1;
            r_rwrap <= w_rwrap_nxt;
            r_rdout <= {r_mem[w_raddr_nxt], w_rwrap_nxt & C_WRAP_ERR};
         end
      end
   end

   // Write FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_wstate <= W_IDLE;
      else      r_wstate <= w_wnext;
   end

   // Write FSM next state and handshake outputs
   always_comb begin
      w_wnext = r_wstate;
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      BVALID  = 1'b0;
      WIDLE   = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            WIDLE = 1'b1;
            if (AWVALID) w_wnext = W_ACK;
         end
         W_ACK: begin
            AWREADY = 1'b1;
            w_wnext = W_DATA;
         end
         W_DATA: begin
            WREADY = 1'b1;
            if (WVALID && WLAST) w_wnext = W_RESP;
         end
         W_RESP: begin
            BVALID = 1'b1;
            if (BREADY) w_wnext = W_IDLE;
         end
         default: w_wnext = W_IDLE;
      endcase
   end

   // Write burst tracking: address, saturating beat count, error accumulation
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_waddr <= 8'd0;
         r_wid   <= 4'd0;
         r_wcnt  <= 5'd0;
         r_werr  <= 1'b0;
         r_wwrap <= 1'b0;
      end else begin
         if (r_wstate == W_IDLE && AWVALID) begin
            r_waddr <= AW[11:4];
            r_wid   <= AW[3:0];
            r_wcnt  <= 5'd0;
            r_werr  <= 1'b0;
            r_wwrap <= 1'b0;
         end
         if (w_whs) begin
            r_waddr <= r_waddr + 8'd1;
            r_wwrap <= r_wwrap | (r_waddr == 8'hFF);
            if (!w_wfull) r_wcnt <= r_wcnt + 5'd1;
            if (w_wfull || (r_wwrap && C_WRAP_ERR)) r_werr <= 1'b1;
         end
      end
   end

   // Storage array is never reset; beats past the 16th are dropped
   always_ff @(posedge clk) begin
      if (w_whs && !w_wfull) r_mem[r_waddr] <= WDATA;
   end

endmodule

// File: tb/tb_burst_slave.sv
module tb_burst_slave;
   logic        clk = 1'b0;
   logic        rst;
   logic        ARVALID, ARREADY, RVALID, RLAST, RREADY, RIDLE;
   logic [15:0] AR;
   logic [8:0]  RDOUT;
   logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY, WIDLE;
   logic [11:0] AW;
   logic [7:0]  WDATA;
   logic [4:0]  BRESP;

   int n_pass = 0;
   int n_chk  = 0;

   logic [8:0] rd_d [0:16];
   logic       rd_l [0:16];
   int         rd_n, rd_ok, rd_arhi, rd_holdbad;
   logic [4:0] wr_bresp;
   int         wr_awhi, wr_ok;

`ifdef BURST_SLAVE_WRAP_ERR_EN
   localparam logic WRAP = 1'b1;
`else
   localparam logic WRAP = 1'b0;
`endif

   burst_slave dut (
      .clk(clk), .rst(rst),
      .ARVALID(ARVALID), .AR(AR), .ARREADY(ARREADY), .RVALID(RVALID), .RLAST(RLAST),
      .RDOUT(RDOUT), .RREADY(RREADY), .RIDLE(RIDLE),
      .AWVALID(AWVALID), .AW(AW), .AWREADY(AWREADY), .WVALID(WVALID), .WLAST(WLAST),
      .WDATA(WDATA), .WREADY(WREADY), .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
      .WIDLE(WIDLE)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [21:0] outv();
      return {ARREADY, RVALID, RLAST, RDOUT, RIDLE, AWREADY, WREADY, BVALID, BRESP, WIDLE};
   endfunction

   task automatic wr_burst(input logic [7:0] addr, input logic [3:0] id, input int n, input logic [7:0] d0);
      int t;
      wr_awhi = 0; wr_ok = 1;
      AWVALID = 1'b1; AW = {addr, id}; t = 0;
      do begin tick(); t++; if (AWREADY) wr_awhi++; end while (!AWREADY && t < 20);
      if (!AWREADY) wr_ok = 0;
      AWVALID = 1'b0;
      for (int i = 0; i < n; i++) begin
         WVALID = 1'b1; WDATA = d0 + 8'(i); WLAST = (i == n - 1);
         t = 0;
         while (!WREADY && t < 20) begin tick(); t++; if (AWREADY) wr_awhi++; end
         if (!WREADY) wr_ok = 0;
         tick(); if (AWREADY) wr_awhi++;
      end
      WVALID = 1'b0; WLAST = 1'b0; t = 0;
      while (!BVALID && t < 20) begin tick(); t++; end
      if (!BVALID) wr_ok = 0;
      wr_bresp = BRESP;
      BREADY = 1'b1; tick(); BREADY = 1'b0;
   endtask

   task automatic rd_burst(input logic [7:0] addr, input logic [3:0] len, input logic stall);
      int t, cyc;
      logic [8:0] held;
      logic have;
      rd_n = 0; rd_ok = 1; rd_arhi = 0; rd_holdbad = 0; have = 1'b0; cyc = 0; held = 9'd0;
      ARVALID = 1'b1; AR = {addr, len, 4'h3}; t = 0;
      do begin tick(); t++; if (ARREADY) rd_arhi++; end while (!ARREADY && t < 20);
      if (!ARREADY) rd_ok = 0;
      ARVALID = 1'b0; t = 0;
      while (rd_n < int'(len) + 1 && t < 200) begin
         RREADY = stall ? cyc[0] : 1'b1;
         if (RVALID) begin
            if (have && RDOUT !== held) rd_holdbad++;
            if (RREADY) begin rd_d[rd_n] = RDOUT; rd_l[rd_n] = RLAST; rd_n++; have = 1'b0; end
            else begin held = RDOUT; have = 1'b1; end
            cyc++;
         end
         tick(); t++; if (ARREADY) rd_arhi++;
      end
      RREADY = 1'b0;
      if (rd_n < int'(len) + 1) rd_ok = 0;
   endtask

   task automatic test_reset();
      #12;
      n_chk++; if (outv() !== 22'h000201) $display("FAIL reset_outputs got %h exp 000201", outv()); else n_pass++;
      @(negedge clk); rst = 1'b1;
      tick();
      n_chk++; if (outv() !== 22'h000201) $display("FAIL idle_outputs got %h exp 000201", outv()); else n_pass++;
   endtask

   task automatic test_write_basic();
      wr_burst(8'h10, 4'd3, 3, 8'hA1);
      n_chk++; if (wr_ok !== 1) $display("FAIL wb_handshake got %0d exp 1", wr_ok); else n_pass++;
      n_chk++; if (wr_awhi !== 1) $display("FAIL wb_awready_pulse got %0d exp 1", wr_awhi); else n_pass++;
      n_chk++; if (wr_bresp !== 5'h06) $display("FAIL wb_bresp got %h exp 06", wr_bresp); else n_pass++;
      n_chk++; if ({WIDLE, BVALID} !== 2'b10) $display("FAIL wb_back_idle got %b exp 10", {WIDLE, BVALID}); else n_pass++;
   endtask

   task automatic test_read_basic();
      rd_burst(8'h10, 4'd2, 1'b0);
      n_chk++; if (rd_ok !== 1) $display("FAIL rb_complete got %0d exp 1", rd_ok); else n_pass++;
      n_chk++; if (rd_arhi !== 1) $display("FAIL rb_arready_pulse got %0d exp 1", rd_arhi); else n_pass++;
      n_chk++; if (rd_d[0] !== 9'h142) $display("FAIL rb_beat0 got %h exp 142", rd_d[0]); else n_pass++;
      n_chk++; if (rd_d[1] !== 9'h144) $display("FAIL rb_beat1 got %h exp 144", rd_d[1]); else n_pass++;
      n_chk++; if (rd_d[2] !== 9'h146) $display("FAIL rb_beat2 got %h exp 146", rd_d[2]); else n_pass++;
      n_chk++; if ({rd_l[0], rd_l[1], rd_l[2]} !== 3'b001) $display("FAIL rb_rlast got %b exp 001", {rd_l[0], rd_l[1], rd_l[2]}); else n_pass++;
      n_chk++; if ({RIDLE, RVALID, RLAST} !== 3'b100) $display("FAIL rb_back_idle got %b exp 100", {RIDLE, RVALID, RLAST}); else n_pass++;
   endtask

   task automatic test_wrap_stall();
      wr_burst(8'hFE, 4'd1, 4, 8'h11);
      n_chk++; if (wr_bresp !== {4'd1, WRAP}) $display("FAIL ws_bresp got %h exp %h", wr_bresp, {4'd1, WRAP}); else n_pass++;
      rd_burst(8'hFE, 4'd3, 1'b1);
      n_chk++; if (rd_ok !== 1) $display("FAIL ws_complete got %0d exp 1", rd_ok); else n_pass++;
      n_chk++; if (rd_holdbad !== 0) $display("FAIL ws_hold_during_stall got %0d exp 0", rd_holdbad); else n_pass++;
      n_chk++; if (rd_d[0] !== 9'h022) $display("FAIL ws_beat_fe got %h exp 022", rd_d[0]); else n_pass++;
      n_chk++; if (rd_d[1] !== 9'h024) $display("FAIL ws_beat_ff got %h exp 024", rd_d[1]); else n_pass++;
      n_chk++; if (rd_d[2] !== {8'h13, WRAP}) $display("FAIL ws_beat_00 got %h exp %h", rd_d[2], {8'h13, WRAP}); else n_pass++;
      n_chk++; if (rd_d[3] !== {8'h14, WRAP}) $display("FAIL ws_beat_01 got %h exp %h", rd_d[3], {8'h14, WRAP}); else n_pass++;
      n_chk++; if ({rd_l[0], rd_l[1], rd_l[2], rd_l[3]} !== 4'b0001) $display("FAIL ws_rlast got %b exp 0001", {rd_l[0], rd_l[1], rd_l[2], rd_l[3]}); else n_pass++;
   endtask

   task automatic test_write_oversize();
      wr_burst(8'h00, 4'd5, 17, 8'hB0);
      n_chk++; if (wr_bresp !== 5'h0B) $display("FAIL wo_bresp got %h exp 0b", wr_bresp); else n_pass++;
      rd_burst(8'h0F, 4'd1, 1'b0);
      n_chk++; if (rd_d[0] !== 9'h17E) $display("FAIL wo_beat16_written got %h exp 17e", rd_d[0]); else n_pass++;
      n_chk++; if (rd_d[1] !== 9'h142) $display("FAIL wo_beat17_dropped got %h exp 142", rd_d[1]); else n_pass++;
   endtask

   task automatic test_overlap();
      wr_burst(8'h40, 4'd7, 1, 8'h55);
      n_chk++; if (wr_bresp !== 5'h0E) $display("FAIL ov_bresp got %h exp 0e", wr_bresp); else n_pass++;
      fork
         wr_burst(8'h40, 4'd7, 1, 8'h66);
         rd_burst(8'h40, 4'd0, 1'b0);
      join
      n_chk++; if (rd_d[0] !== 9'h0AA) $display("FAIL ov_read_old got %h exp 0aa", rd_d[0]); else n_pass++;
      n_chk++; if (wr_ok !== 1) $display("FAIL ov_write_done got %0d exp 1", wr_ok); else n_pass++;
      rd_burst(8'h40, 4'd0, 1'b0);
      n_chk++; if (rd_d[0] !== 9'h0CC) $display("FAIL ov_read_new got %h exp 0cc", rd_d[0]); else n_pass++;
   endtask

   task automatic test_reset_midburst();
      int t, bv;
      AWVALID = 1'b1; AW = {8'h80, 4'd2}; t = 0;
      do begin tick(); t++; end while (!AWREADY && t < 20);
      n_chk++; if (AWREADY !== 1'b1) $display("FAIL rm_awready got %b exp 1", AWREADY); else n_pass++;
      AWVALID = 1'b0;
      tick();
      WVALID = 1'b1; WDATA = 8'hC1; WLAST = 1'b0;
      tick();
      WDATA = 8'hC2;
      #2 rst = 1'b0;
      #1;
      n_chk++; if (outv() !== 22'h000201) $display("FAIL rm_outputs_cleared got %h exp 000201", outv()); else n_pass++;
      WVALID = 1'b0; bv = 0;
      for (int i = 0; i < 3; i++) begin tick(); if (BVALID) bv++; end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin tick(); if (BVALID || !WIDLE) bv++; end
      n_chk++; if (bv !== 0) $display("FAIL rm_no_bvalid got %0d exp 0", bv); else n_pass++;
      rd_burst(8'h80, 4'd0, 1'b0);
      n_chk++; if (rd_d[0] !== 9'h182) $display("FAIL rm_first_beat_kept got %h exp 182", rd_d[0]); else n_pass++;
   endtask

   initial begin
      rst = 1'b0;
      ARVALID = 1'b0; AR = 16'd0; RREADY = 1'b0;
      AWVALID = 1'b0; AW = 12'd0; WVALID = 1'b0; WLAST = 1'b0; WDATA = 8'd0; BREADY = 1'b0;
      test_reset();
      test_write_basic();
      test_read_basic();
      test_wrap_stall();
      test_write_oversize();
      test_overlap();
      test_reset_midburst();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/burst_slave.md
BURST_SLAVE -- requirements
Module: burst_slave

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 ARVALID  input  1  read address valid.
REQ-004 AR  input  16  [15:8] ARADDR, [7:4] ARLEN (beats-1), [3:0] ARID.
REQ-005 ARREADY  output  1  read address accepted.
REQ-006 RVALID  output  1  read beat valid.
REQ-007 RLAST  output  1  final read beat.
REQ-008 RDOUT  output  9  [8:1] read data, [0] RRESP (1=error).
REQ-009 RREADY  input  1  initiator accepts read beat.
REQ-010 RIDLE  output  1  read side idle.
REQ-011 AWVALID  input  1  write address valid.
REQ-012 AW  input  12  [11:4] AWADDR, [3:0] AWID.
REQ-013 AWREADY  output  1  write address accepted.
REQ-014 WVALID, WLAST  input  1 each  write beat valid / final write beat.
REQ-015 WDATA  input  8  write data.
REQ-016 WREADY  output  1  slave accepts write beats.
REQ-017 BVALID  output  1  write response valid.
REQ-018 BRESP  output  5  [4:1] AWID, [0] error.
REQ-019 BREADY  input  1  initiator accepts response.
REQ-020 WIDLE  output  1  write side idle.

Function
REQ-021 Storage: 256 x 8 internal array; address arithmetic 8-bit, increments by 1 per beat, 0xFF wraps to 0x00.
REQ-022 Read FSM states R_IDLE, R_ACK, R_DATA; write FSM states W_IDLE, W_ACK, W_DATA, W_RESP; both FSMs independent and concurrent.
REQ-023 R_IDLE: RIDLE=1, outputs low; ARVALID sampled high -> latch AR, go R_ACK.
REQ-024 R_ACK: ARREADY=1 for exactly one cycle; next cycle R_DATA with ARREADY=0.
REQ-025 R_DATA: RVALID=1, RDOUT holds current beat; beat advances only on RVALID&&RREADY; RLAST=1 on beat ARLEN (ARLEN+1 beats total, 1..16).
REQ-026 Handshake on last beat -> RVALID=0, RLAST=0, return R_IDLE next cycle; RDOUT held stable while RVALID&&!RREADY.
REQ-027 W_IDLE: WIDLE=1; AWVALID sampled high -> latch AW, go W_ACK; W_ACK: AWREADY=1 one cycle, then W_DATA.
REQ-028 W_DATA: WREADY=1; each WVALID&&WREADY writes WDATA to current address, then increments address and 5-bit beat count.
REQ-029 Beats beyond the 16th are not written, set error; WREADY stays 1 until WLAST.
REQ-030 WLAST beat accepted -> WREADY=0, go W_RESP; BVALID=1, BRESP={AWID,err} held until BREADY; then W_IDLE.
REQ-031 Same-address read/write in one cycle: read beat returns pre-write data; write completes.
REQ-032 ARVALID/AWVALID while not idle are ignored (not latched).

Reset
REQ-033 rst low asynchronously forces both FSMs idle, all outputs 0 except RIDLE=1, WIDLE=1; burst counters and error flags cleared.
REQ-034 Reset mid-burst aborts it: no further beats, no BVALID; array contents not reset (already-written beats retained).

Configuration
REQ-035 Macro BURST_SLAVE_WRAP_ERR_EN: defined -> any read beat whose address wrapped past 0xFF sets RRESP=1 on that beat, any wrapped write sets BRESP[0]=1; undefined -> wrap is silent, only oversize writes set error. Data path identical either way.

Verification
REQ-036 Write AW=0x10/ID 3, beats 0xA1,0xA2,0xA3 (WLAST on 3rd) -> AWREADY one-cycle pulse, BRESP=0x06, mem[0x10..0x12]=A1,A2,A3.
REQ-037 Read AR=0x1023 (addr 0x10, ARLEN 2, ID 3), RREADY=1 -> ARREADY pulse, three beats RDOUT=0x142,0x144,0x146, RLAST on third only.
REQ-038 Read ARLEN 3 at 0xFE with RREADY toggled 1/0 -> data held during stalls; with macro, RRESP=1 on beats at 0x00,0x01; without, all RRESP=0.
REQ-039 Write 17 beats at 0x00, ID 5 -> mem[0x10] unchanged, BRESP=0x0B.
REQ-040 Read and write bursts overlapped, same address 0x40 in same cycle -> read returns old value, later read returns new.
REQ-041 rst low during 2nd beat of 4-beat write -> outputs cleared within cycle, no BVALID, RIDLE=WIDLE=1, first beat retained in array.
